win_scan_ctrl: RTL and testbench

Reader-side controller for the line-buffer cascade. It tracks the raster position of the pixel stream feeding the first buffer stage. It tells the downstream detector exactly which cycles see a complete, fully in-image WIN_W × WIN_H window on the tap outputs. It also reports frame completion and stream-protocol errors, because the buffer stages shift every clock and have no flow control of their own.

---
 rtl/win_scan_pkg.sv | 21 ++
 rtl/raster_counter.sv | 55 +++++
 rtl/win_scan_ctrl.sv | 139 +++++++++++++
 tb/tb_win_scan_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/win_scan_pkg.sv
// rtl/win_scan_pkg.sv - shared types, default geometry and width helper for the window scan controller
package win_scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2,
        ERR  = 2'd3
    } scan_state_e;

    localparam int DEF_IMAGE_WIDTH  = 640;
    localparam int DEF_IMAGE_HEIGHT = 480;
    localparam int DEF_WIN_W        = 52;
    localparam int DEF_WIN_H        = 52;

    // A dimension of 1 still needs one bit so the ports never collapse to zero width.
    function automatic int cnt_width(input int dim);
        return (dim <= 1) ? 1 : $clog2(dim);
    endfunction

endpackage

// File: rtl/raster_counter.sv
// rtl/raster_counter.sv - col/row raster position with wrap, origin load and enable
module raster_counter
    import win_scan_pkg::*;
#(
    parameter int WIDTH  = DEF_IMAGE_WIDTH,
    parameter int HEIGHT = DEF_IMAGE_HEIGHT,
    localparam int CW    = cnt_width(WIDTH),
    localparam int RW    = cnt_width(HEIGHT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_origin_i,
    input  logic          enable_i,
    output logic [CW-1:0] col_in_o,
    output logic [RW-1:0] row_in_o
);

    localparam logic [CW-1:0] COL_MAX = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(HEIGHT - 1);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;

    // Position of the pixel on the input this cycle; a start-of-frame pixel is (0,0).
    assign col_in_o = load_origin_i ? '0 : col_q;
    assign row_in_o = load_origin_i ? '0 : row_q;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (enable_i) begin
            if (col_in_o == COL_MAX) begin
                col_d = '0;
                row_d = (row_in_o == ROW_MAX) ? '0 : row_in_o + 1'b1;
            end else begin
                col_d = col_in_o + 1'b1;
                row_d = row_in_o;
            end
        end else if (load_origin_i) begin
            col_d = '0;
            row_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/win_scan_ctrl.sv
// rtl/win_scan_ctrl.sv - raster tracker flagging complete in-image windows on the line-buffer taps
module win_scan_ctrl
    import win_scan_pkg::*;
#(
    parameter int IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
    parameter int WIN_W        = DEF_WIN_W,
    parameter int WIN_H        = DEF_WIN_H,
    localparam int CW          = cnt_width(IMAGE_WIDTH),
    localparam int RW          = cnt_width(IMAGE_HEIGHT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_valid,
    input  logic          pix_sof,
    output logic          win_valid,
    output logic [CW-1:0] win_col,
    output logic [RW-1:0] win_row,
    output logic          eol,
    output logic          frame_done,
    output logic          err
);

    if (WIN_W > IMAGE_WIDTH || WIN_H > IMAGE_HEIGHT) begin : g_geom_check
        $error("win_scan_ctrl: window larger than image");
    end

    localparam logic [CW-1:0] COL_MAX    = CW'(IMAGE_WIDTH - 1);
    localparam logic [RW-1:0] ROW_MAX    = RW'(IMAGE_HEIGHT - 1);
    localparam logic [CW-1:0] COL_WIN_M1 = CW'(WIN_W - 1);
    localparam logic [RW-1:0] ROW_WIN_M1 = RW'(WIN_H - 1);

    scan_state_e state_q, state_d;

    logic          accept, restart;
    logic [CW-1:0] col_in;
    logic [RW-1:0] row_in;
    logic          last_col, last_pix, rows_full;

    logic          win_valid_q, win_valid_d;
    logic [CW-1:0] win_col_q, win_col_d;
    logic [RW-1:0] win_row_q, win_row_d;
    logic          eol_q, eol_d;
    logic          frame_done_q, frame_done_d;
    logic          err_q, err_d;

    raster_counter #(
        .WIDTH  (IMAGE_WIDTH),
        .HEIGHT (IMAGE_HEIGHT)
    ) u_raster (
        .clk           (clk),
        .rst           (rst),
        .load_origin_i (restart),
        .enable_i      (accept),
        .col_in_o      (col_in),
        .row_in_o      (row_in)
    );

    assign last_col  = (col_in == COL_MAX);
    assign last_pix  = last_col && (row_in == ROW_MAX);
    assign rows_full = (row_in >= ROW_WIN_M1);

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        restart = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pix_valid && pix_sof) begin
                    accept  = 1'b1;
                    restart = 1'b1;
                end
            end
            ERR: begin
                err_d = 1'b1;
                if (pix_valid && pix_sof) begin
                    accept  = 1'b1;
                    restart = 1'b1;
                    err_d   = 1'b0;
                end
            end
            FILL, RUN: begin
                // The cascade shifts every clock, so a gap corrupts the taps.
                if (!pix_valid) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end else begin
                    accept = 1'b1;
                    if (pix_sof) begin
                        restart = 1'b1;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            if (last_pix)       state_d = IDLE;
            else if (rows_full) state_d = RUN;
            else                state_d = FILL;
        end

        win_valid_d  = accept && rows_full && (col_in >= COL_WIN_M1);
        win_col_d    = win_valid_d ? col_in - COL_WIN_M1 : '0;
        win_row_d    = win_valid_d ? row_in - ROW_WIN_M1 : '0;
        eol_d        = accept && last_col;
        frame_done_d = accept && last_pix;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            win_valid_q  <= 1'b0;
            win_col_q    <= '0;
            win_row_q    <= '0;
            eol_q        <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            win_valid_q  <= win_valid_d;
            win_col_q    <= win_col_d;
            win_row_q    <= win_row_d;
            eol_q        <= eol_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

    assign win_valid  = win_valid_q;
    assign win_col    = win_col_q;
    assign win_row    = win_row_q;
    assign eol        = eol_q;
    assign frame_done = frame_done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_win_scan_ctrl.sv
// tb/tb_win_scan_ctrl.sv - directed self-checking bench for win_scan_ctrl
module tb_win_scan_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pv = 1'b0, ps = 1'b0;
    logic wv, eol, fd, err;
    logic [2:0] wc;
    logic [2:0] wr;

    logic p2v = 1'b0, p2s = 1'b0;
    logic wv2, eol2, fd2, err2;
    logic [9:0] wc2;
    logic [8:0] wr2;

    int n_tests = 0;
    int n_fail  = 0;

    int nw, neol, nfd, nerr, nact, fd_bad, first_idx, cur_idx;
    int first_col, first_row, last_col, last_row;

    always #5 clk = ~clk;

    win_scan_ctrl #(.IMAGE_WIDTH(8), .IMAGE_HEIGHT(6), .WIN_W(3), .WIN_H(3)) dut (
        .clk(clk), .rst(rst), .pix_valid(pv), .pix_sof(ps),
        .win_valid(wv), .win_col(wc), .win_row(wr),
        .eol(eol), .frame_done(fd), .err(err)
    );

    win_scan_ctrl dut_def (
        .clk(clk), .rst(rst), .pix_valid(p2v), .pix_sof(p2s),
        .win_valid(wv2), .win_col(wc2), .win_row(wr2),
        .eol(eol2), .frame_done(fd2), .err(err2)
    );

    task automatic clr_stats();
        nw = 0; neol = 0; nfd = 0; nerr = 0; nact = 0; fd_bad = 0; first_idx = -1;
        first_col = -1; first_row = -1; last_col = -1; last_row = -1;
    endtask

    // Drive one cycle; on return the outputs belong to the pixel just driven.
    task automatic px(input logic v, input logic s);
        pv = v; ps = s;
        @(posedge clk); #1;
        if (wv) begin
            nw++;
            if (first_idx < 0) begin
                first_idx = cur_idx; first_col = int'(wc); first_row = int'(wr);
            end
            last_col = int'(wc); last_row = int'(wr);
        end
        if (eol) neol++;
        if (fd) begin
            nfd++;
            if (!(wv && eol)) fd_bad++;
        end
        if (err) nerr++;
        if (wv || eol || fd || err || wc != 0 || wr != 0) nact++;
    endtask

    task automatic frame();
        for (int i = 0; i < 48; i++) begin
            cur_idx = i;
            px(1'b1, i == 0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; pv = 1'b0; ps = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({wv, wc, wr, eol, fd, err} !== 10'b0) begin
            n_fail++; $display("FAIL reset_outputs: got %b want 0", {wv, wc, wr, eol, fd, err});
        end
        rst = 1'b0;
    endtask

    task automatic test_single_frame();
        clr_stats();
        frame();
        n_tests++; if (nw !== 24) begin n_fail++; $display("FAIL single_win_count: got %0d want 24", nw); end
        n_tests++; if (first_idx !== 18) begin n_fail++; $display("FAIL single_first_idx: got %0d want 18", first_idx); end
        n_tests++; if (first_row !== 0 || first_col !== 0) begin n_fail++; $display("FAIL single_first_rc: got (%0d,%0d) want (0,0)", first_row, first_col); end
        n_tests++; if (last_row !== 3 || last_col !== 5) begin n_fail++; $display("FAIL single_last_rc: got (%0d,%0d) want (3,5)", last_row, last_col); end
        n_tests++; if (neol !== 6) begin n_fail++; $display("FAIL single_eol: got %0d want 6", neol); end
        n_tests++; if (nfd !== 1 || fd_bad !== 0) begin n_fail++; $display("FAIL single_frame_done: got %0d (uncoincident %0d) want 1 (0)", nfd, fd_bad); end
        n_tests++; if (nerr !== 0) begin n_fail++; $display("FAIL single_err: got %0d want 0", nerr); end
        clr_stats();
        px(1'b0, 1'b0);
        px(1'b1, 1'b0);
        n_tests++; if (nact !== 0) begin n_fail++; $display("FAIL idle_ignores: got %0d active cycles want 0", nact); end
    endtask

    task automatic test_back_to_back();
        clr_stats();
        frame();
        frame();
        n_tests++; if (nw !== 48) begin n_fail++; $display("FAIL b2b_win_count: got %0d want 48", nw); end
        n_tests++; if (nfd !== 2) begin n_fail++; $display("FAIL b2b_frame_done: got %0d want 2", nfd); end
        n_tests++; if (nerr !== 0) begin n_fail++; $display("FAIL b2b_err: got %0d want 0", nerr); end
    endtask

    task automatic test_drop();
        clr_stats();
        for (int i = 0; i < 28; i++) begin
            cur_idx = i;
            px(1'b1, i == 0);
        end
        px(1'b0, 1'b0);
        n_tests++; if (err !== 1'b1 || wv !== 1'b0) begin n_fail++; $display("FAIL drop_err: got err=%b wv=%b want 1 0", err, wv); end
        clr_stats();
        for (int i = 0; i < 5; i++) px(1'b1, 1'b0);
        n_tests++; if (nerr !== 5 || nw !== 0) begin n_fail++; $display("FAIL drop_sticky: got err=%0d wv=%0d want 5 0", nerr, nw); end
        clr_stats();
        cur_idx = 0;
        px(1'b1, 1'b1);
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL drop_clear: got %b want 0", err); end
        for (int i = 1; i < 48; i++) begin
            cur_idx = i;
            px(1'b1, 1'b0);
        end
        n_tests++; if (nw !== 24 || nfd !== 1 || nerr !== 0) begin n_fail++; $display("FAIL drop_recover: got win=%0d fd=%0d err=%0d want 24 1 0", nw, nfd, nerr); end
    endtask

    task automatic test_sof_abort();
        for (int i = 0; i < 20; i++) begin
            cur_idx = i;
            px(1'b1, i == 0);
        end
        clr_stats();
        cur_idx = 0;
        px(1'b1, 1'b1);
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL abort_err_pulse: got %b want 1", err); end
        for (int i = 1; i < 48; i++) begin
            cur_idx = i;
            px(1'b1, 1'b0);
        end
        n_tests++; if (nerr !== 1) begin n_fail++; $display("FAIL abort_err_len: got %0d want 1", nerr); end
        n_tests++; if (first_idx !== 18) begin n_fail++; $display("FAIL abort_first_idx: got %0d want 18", first_idx); end
        n_tests++; if (nw !== 24 || nfd !== 1) begin n_fail++; $display("FAIL abort_frame: got win=%0d fd=%0d want 24 1", nw, nfd); end
    endtask

    task automatic test_rst_mid();
        for (int i = 0; i < 26; i++) begin
            cur_idx = i;
            px(1'b1, i == 0);
        end
        rst = 1'b1;
        clr_stats();
        px(1'b1, 1'b1);
        rst = 1'b0;
        n_tests++; if ({wv, wc, wr, eol, fd, err} !== 10'b0) begin n_fail++; $display("FAIL rst_mid_outputs: got %b want 0", {wv, wc, wr, eol, fd, err}); end
        clr_stats();
        for (int i = 0; i < 10; i++) px(1'b1, 1'b0);
        n_tests++; if (nact !== 0) begin n_fail++; $display("FAIL rst_no_sof: got %0d active cycles want 0", nact); end
        clr_stats();
        frame();
        n_tests++; if (nw !== 24 || nfd !== 1) begin n_fail++; $display("FAIL rst_recover: got win=%0d fd=%0d want 24 1", nw, nfd); end
        pv = 1'b0; ps = 1'b0;
    endtask

    task automatic test_defaults();
        int f2, n2, fr, fc;
        f2 = -1; n2 = 0; fr = -1; fc = -1;
        for (int i = 0; i <= 51 * 640 + 52; i++) begin
            p2v = 1'b1; p2s = (i == 0);
            @(posedge clk); #1;
            if (wv2) begin
                n2++;
                if (f2 < 0) begin f2 = i; fr = int'(wr2); fc = int'(wc2); end
            end
        end
        p2v = 1'b0; p2s = 1'b0;
        n_tests++; if (f2 !== 51 * 640 + 51) begin n_fail++; $display("FAIL def_first_idx: got %0d want %0d", f2, 51 * 640 + 51); end
        n_tests++; if (fr !== 0 || fc !== 0 || n2 !== 2) begin n_fail++; $display("FAIL def_first_rc: got (%0d,%0d) n=%0d want (0,0) n=2", fr, fc, n2); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_drop();
        test_sof_abort();
        test_rst_mid();
        test_defaults();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
